// File: rtl/link_pkg.sv
// Shared constants and types for the inter-board PMOD link (receive and transmit sides).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package link_pkg;

    localparam int LINK_DATA_W = 12;
    localparam int LINK_HALF_W = 6;
    localparam int LINK_PINS   = 8;

    // Pin roles on the 8-pin link; payload occupies [LINK_HALF_W-1:0]
    localparam int STROBE_BIT  = 7;
    localparam int START_BIT   = 6;

    // Frame reassembly state: waiting for the start (high) beat or the low beat
    typedef enum logic {
        WAIT_HI,
        WAIT_LO
    } link_state_t;

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-stage flip-flop synchroniser for a bus of independent asynchronous pins.
// Latency: STAGES clk cycles from pin to dout.
// Backpressure: none; samples every cycle.
module pin_synchronizer #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift each pin through the flop chain; the first stage may go metastable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/link_frame_receiver.sv
// Receives two 6-bit beats per frame over the PMOD link, reassembles the 12-bit word, flags framing errors, tracks link liveness.
// Latency: SYNC_STAGES+1 clk cycles from strobe rise at the pins to data_valid / frame_err.
// Backpressure: none; the peer cannot be stalled, every word is presented once. Build macro LINK_TIMEOUT_CLEAR_EN zeroes keyboard_data on link loss.
module link_frame_receiver
    import link_pkg::*;
#(
    parameter int DATA_W      = LINK_DATA_W,
    parameter int HALF_W      = LINK_HALF_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LINK_PINS-1:0] rx_pins,
    output logic [DATA_W-1:0]    keyboard_data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [7:0]           err_count,
    output logic                 link_up
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [LINK_PINS-1:0] pins_sync;
    logic                 strobe_prev;
    logic                 beat;
    logic                 start_flag;
    logic [HALF_W-1:0]    payload;
    logic [HALF_W-1:0]    hi_half;
    link_state_t          state, next_state;
    logic                 latch_hi;
    logic                 word_done;
    logic                 framing_err;
    logic [CNT_W-1:0]     idle_cnt;
    logic                 timeout_hit;

    pin_synchronizer #(
        .WIDTH  (LINK_PINS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rx_pins),
        .dout  (pins_sync)
    );

    // Data is stable at the strobe rise because the peer changes it on the fall
    assign beat        = pins_sync[STROBE_BIT] & ~strobe_prev;
    assign start_flag  = pins_sync[START_BIT];
    assign payload     = pins_sync[HALF_W-1:0];
    assign timeout_hit = (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Remember the previous synchronised strobe for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) strobe_prev <= 1'b0;
        else        strobe_prev <= pins_sync[STROBE_BIT];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_HI;
        else        state <= next_state;
    end

    // Frame decode: a start beat always (re)opens a frame, a second start is an error
    always_comb begin
        next_state  = state;
        latch_hi    = 1'b0;
        word_done   = 1'b0;
        framing_err = 1'b0;
        if (beat) begin
            case (state)
                WAIT_HI: begin
                    if (start_flag) begin
                        latch_hi   = 1'b1;
                        next_state = WAIT_LO;
                    end else begin
                        framing_err = 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (start_flag) begin
                        framing_err = 1'b1;
                        latch_hi    = 1'b1;
                    end else begin
                        word_done  = 1'b1;
                        next_state = WAIT_HI;
                    end
                end
                default: next_state = WAIT_HI;
            endcase
        end
    end

    // Capture the high half of the frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        hi_half <= '0;
        else if (latch_hi) hi_half <= payload;
    end

    // Output word; optionally forced to zero when the link drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keyboard_data <= '0;
        end else if (word_done) begin
            keyboard_data <= {hi_half, payload};
`ifdef LINK_TIMEOUT_CLEAR_EN
        end else if (timeout_hit && link_up) begin
            keyboard_data <= '0;
`endif
        end
    end

    // One-cycle event pulses and the saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            data_valid <= word_done;
            frame_err  <= framing_err;
            if (framing_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // Cycles since the last good word, saturating at the timeout value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  idle_cnt <= '0;
        else if (word_done)                          idle_cnt <= '0;
        else if (idle_cnt != CNT_W'(TIMEOUT_CYC))    idle_cnt <= idle_cnt + 1'b1;
    end

    // Link liveness: a fresh word beats a simultaneous timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           link_up <= 1'b0;
        else if (word_done)   link_up <= 1'b1;
        else if (timeout_hit) link_up <= 1'b0;
    end

endmodule

// File: tb/tb_link_frame_receiver.sv
// Directed bench for link_frame_receiver with a frame-level reference model checked every cycle.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_link_frame_receiver;
    import link_pkg::*;

    localparam int T = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_pins = '0;
    logic [11:0] keyboard_data;
    logic        data_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        link_up;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    link_frame_receiver #(
        .DATA_W      (12),
        .HALF_W      (6),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pins       (rx_pins),
        .keyboard_data (keyboard_data),
        .data_valid    (data_valid),
        .frame_err     (frame_err),
        .err_count     (err_count),
        .link_up       (link_up)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames are judged by the strobe rises the bench puts on the pins;
    // every result appears two samples after the rise is sampled (SYNC_STAGES+1 cycles).
    logic [7:0]  smp [4];
    int          mcyc = 0;
    int          last_v = 0;
    bit          seen = 0;
    bit          have_hi = 0;
    logic [5:0]  mhi = '0;
    logic [11:0] ekd = '0;
    int          eerr = 0;
    bit          edv = 0;
    bit          efe = 0;
    bit          elink = 0;

    always @(posedge clk) begin
        #1;
        mcyc++;
        edv = 0;
        efe = 0;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) smp[i] = '0;
            seen = 0;
            have_hi = 0;
            mhi = '0;
            ekd = '0;
            eerr = 0;
        end else begin
            smp[3] = smp[2];
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = rx_pins;
            if (smp[2][7] && !smp[3][7]) begin
                if (smp[2][6]) begin
                    if (have_hi) efe = 1;
                    mhi = smp[2][5:0];
                    have_hi = 1;
                end else if (have_hi) begin
                    ekd = {mhi, smp[2][5:0]};
                    edv = 1;
                    have_hi = 0;
                    seen = 1;
                    last_v = mcyc;
                end else begin
                    efe = 1;
                end
            end
            if (efe && eerr < 255) eerr++;
`ifdef LINK_TIMEOUT_CLEAR_EN
            if (seen && (mcyc - last_v) >= T) ekd = '0;
`endif
        end
        elink = seen && ((mcyc - last_v) < T);
        chk("cyc_keyboard_data", int'(keyboard_data), int'(ekd));
        chk("cyc_data_valid",    int'(data_valid),    int'(edv));
        chk("cyc_frame_err",     int'(frame_err),     int'(efe));
        chk("cyc_err_count",     int'(err_count),     eerr);
        chk("cyc_link_up",       int'(link_up),       int'(elink));
    end

    // Observations taken during the last beat
    bit dv2, dv3, fe3;
    int dv_cyc = 0;

    // One beat: set data with strobe low, raise strobe, hold, drop strobe
    task automatic beat(input bit st, input logic [5:0] pay);
        rx_pins = {1'b0, st, pay};
        repeat (3) @(negedge clk);
        rx_pins[7] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dv2 = data_valid;
        @(negedge clk);
        dv3 = data_valid;
        fe3 = frame_err;
        if (dv3) dv_cyc = cyc;
        @(negedge clk);
        rx_pins[7] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int fall_cyc;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_keyboard_data", int'(keyboard_data), 0);
        chk("rst_data_valid",    int'(data_valid),    0);
        chk("rst_err_count",     int'(err_count),     0);
        chk("rst_link_up",       int'(link_up),       0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame 2A / 15 -> A95, valid exactly 3 cycles after the strobe rise
        beat(1'b1, 6'h2A);
        beat(1'b0, 6'h15);
        chk("good_dv_early",  int'(dv2), 0);
        chk("good_dv_lat3",   int'(dv3), 1);
        chk("good_word",      int'(keyboard_data), 12'hA95);
        chk("good_link_up",   int'(link_up), 1);
        chk("good_err_count", int'(err_count), 0);

        // Orphan low beat
        beat(1'b0, 6'h11);
        chk("orphan_fe",        int'(fe3), 1);
        chk("orphan_err_count", int'(err_count), 1);
        chk("orphan_word_held", int'(keyboard_data), 12'hA95);

        // Double start resynchronises on the second start
        beat(1'b1, 6'h3F);
        beat(1'b1, 6'h01);
        chk("dbl_fe", int'(fe3), 1);
        beat(1'b0, 6'h02);
        chk("dbl_dv",        int'(dv3), 1);
        chk("dbl_word",      int'(keyboard_data), 12'h042);
        chk("dbl_err_count", int'(err_count), 2);

        // Timeout: strobe stopped, link_up falls T cycles after data_valid
        n = 0;
        while (link_up && n < 4 * T) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
        chk("to_link_down", int'(link_up), 0);
        chk("to_delay", fall_cyc - dv_cyc, T);
`ifdef LINK_TIMEOUT_CLEAR_EN
        chk("to_word", int'(keyboard_data), 0);
`else
        chk("to_word", int'(keyboard_data), 12'h042);
`endif

        // Error counter saturation
        repeat (300) beat(1'b0, 6'h00);
        chk("sat_255", int'(err_count), 255);
        beat(1'b0, 6'h00);
        chk("sat_hold", int'(err_count), 255);

        // Reset mid-frame, then a fresh frame 04 / 23 -> 123
        beat(1'b1, 6'h12);
        rst_n = 1'b0;
        #1;
        chk("mrst_word",      int'(keyboard_data), 0);
        chk("mrst_err_count", int'(err_count), 0);
        chk("mrst_link_up",   int'(link_up), 0);
        chk("mrst_pulses",    int'({data_valid, frame_err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(1'b1, 6'h04);
        beat(1'b0, 6'h23);
        chk("post_dv",        int'(dv3), 1);
        chk("post_word",      int'(keyboard_data), 12'h123);
        chk("post_err_count", int'(err_count), 0);
        chk("post_link_up",   int'(link_up), 1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
